// File: rtl/note_gen_param.sv
// Square-wave note generator: 12 chromatic notes over 8 octaves, glitch-free
// note changes at half-period boundaries and a clean drain on stop.
module note_gen_param #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             note_we,
  input  logic [3:0]       note_sel,
  input  logic [2:0]       octave,
  output logic             tone_out,
  output logic             active,
  output logic             tick,
  output logic [CNT_W-1:0] half_per
);

  localparam int unsigned NOTES = 12;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Octave-4 half-periods in clk cycles, C..B
  localparam logic [CNT_W-1:0] H_BASE [NOTES] = '{
    CNT_W'(CLK_HZ / (2 * 262)), CNT_W'(CLK_HZ / (2 * 277)),
    CNT_W'(CLK_HZ / (2 * 294)), CNT_W'(CLK_HZ / (2 * 311)),
    CNT_W'(CLK_HZ / (2 * 330)), CNT_W'(CLK_HZ / (2 * 349)),
    CNT_W'(CLK_HZ / (2 * 370)), CNT_W'(CLK_HZ / (2 * 392)),
    CNT_W'(CLK_HZ / (2 * 415)), CNT_W'(CLK_HZ / (2 * 440)),
    CNT_W'(CLK_HZ / (2 * 466)), CNT_W'(CLK_HZ / (2 * 494))
  };

  function automatic logic [CNT_W-1:0] half_for(input logic [3:0] n, input logic [2:0] o);
    logic [CNT_W-1:0] base;
    base = (n < 4'd12) ? H_BASE[n] : '0;
    if (o >= 3'd4) half_for = base >> (o - 3'd4);
    else           half_for = base << (3'd4 - o);
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [CNT_W-1:0] half_n;
  logic             tone_n, tick_n;
  logic [3:0]       pend_note;
  logic [2:0]       pend_oct;
  logic [CNT_W-1:0] pend_half;
  logic             pend_rest;
  logic             boundary;

  assign pend_half = half_for(pend_note, pend_oct);
  assign pend_rest = (pend_note >= 4'd12);
  assign boundary  = (count == half_per - CNT_W'(1));

  // Pending note register; boundary reloads read the pre-write value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_note <= 4'd9;
      pend_oct  <= 3'd4;
    end else if (note_we) begin
      pend_note <= note_sel;
      pend_oct  <= octave;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      tone_out <= 1'b0;
      tick     <= 1'b0;
      half_per <= '0;
      active   <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      tone_out <= tone_n;
      tick     <= tick_n;
      half_per <= half_n;
      active   <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    tone_n  = tone_out;
    tick_n  = 1'b0;
    half_n  = half_per;
    unique case (state)
      IDLE: begin
        count_n = '0;
        tone_n  = 1'b0;
        if (enable && !pend_rest) begin
          state_n = RUN;
          tone_n  = 1'b1;
          tick_n  = 1'b1;
          half_n  = pend_half;
        end
      end
      RUN: begin
        count_n = count + CNT_W'(1);
        if (!enable && !tone_out) begin
          state_n = IDLE;
          count_n = '0;
        end else if (boundary) begin
          count_n = '0;
          tone_n  = !tone_out;
          tick_n  = 1'b1;
          // A falling edge with stop or rest pending ends the tone here
          if (tone_out && (!enable || pend_rest)) state_n = IDLE;
          else if (!pend_rest)                    half_n  = pend_half;
        end else if (!enable) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        count_n = count + CNT_W'(1);
        if (boundary) begin
          count_n = '0;
          tone_n  = 1'b0;
          tick_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_note_gen_param.sv
// Bench for note_gen_param: directed test-plan steps plus random traffic,
// compared every cycle against a countdown-based reference model.
module tb_note_gen_param;

  localparam int unsigned CLK_HZ = 88000;
  localparam int unsigned CNT_W  = 25;

  logic             clk = 1'b0;
  logic             reset, enable, note_we;
  logic [3:0]       note_sel;
  logic [2:0]       octave;
  logic             tone_out, active, tick;
  logic [CNT_W-1:0] half_per;

  int checks   = 0;
  int failures = 0;

  int unsigned freq_hz [12] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};

  // Reference model: playing flag, drain flag, level, cycles left in this half
  bit          m_play, m_drain, m_level, m_tick;
  int          m_left;
  int unsigned m_half;
  int          m_pn, m_po;

  always #5 clk = ~clk;

  note_gen_param #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .note_we(note_we),
    .note_sel(note_sel), .octave(octave), .tone_out(tone_out),
    .active(active), .tick(tick), .half_per(half_per)
  );

  function automatic int unsigned ref_half(input int n, input int o);
    longint h;
    h = longint'(CLK_HZ / (2 * freq_hz[n]));
    if (o >= 4) h = h / (longint'(1) << (o - 4));
    else        h = h * (longint'(1) << (4 - o));
    return int'(h % (longint'(1) << CNT_W));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("tone_out", 64'(tone_out), 64'(m_level));
    check("active",   64'(active),   64'(m_play));
    check("tick",     64'(tick),     64'(m_tick));
    check("half_per", 64'(half_per), 64'(m_half));
  endtask

  task automatic model_reset();
    m_play = 0; m_drain = 0; m_level = 0; m_tick = 0;
    m_left = 0; m_half = 0; m_pn = 9; m_po = 4;
  endtask

  task automatic model_step(input bit en, input bit we, input int ns, input int oc);
    m_tick = 0;
    if (!m_play) begin
      if (en && m_pn < 12) begin
        m_play = 1; m_level = 1; m_tick = 1;
        m_half = ref_half(m_pn, m_po);
        m_left = int'(m_half);
      end
    end else if (!m_drain && !en && !m_level) begin
      m_play = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_tick = 1;
        if (m_level && (m_drain || !en || m_pn >= 12)) begin
          m_level = 0; m_play = 0; m_drain = 0;
        end else begin
          m_level = !m_level;
          if (m_pn < 12) m_half = ref_half(m_pn, m_po);
          m_left = int'(m_half);
        end
      end else if (!en) begin
        m_drain = 1;
      end
    end
    if (we) begin m_pn = ns; m_po = oc; end
  endtask

  task automatic cyc(input bit en, input bit we, input int ns, input int oc);
    enable = en; note_we = we; note_sel = 4'(ns); octave = 3'(oc);
    @(posedge clk);
    model_step(en, we, ns, oc);
    #1;
    check_all();
    note_we = 1'b0;
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(en, 1'b0, 0, 0);
  endtask

  // Advance with enable high until the model sees a toggle to want_level
  task automatic wait_edge(input bit want_level, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      cyc(1'b1, 1'b0, 0, 0);
      if (m_tick && m_level == want_level) found = 1;
    end
    check("wait_edge", 64'(found), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; note_we = 1'b0; note_sel = '0; octave = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Start with default A4
    cyc(1, 0, 0, 0);
    check("start_tone", 64'(tone_out), 64'd1);
    check("start_half", 64'(half_per), 64'd100);
    run(450, 1);

    // Note change 30 cycles into a high half
    wait_edge(1, 300);
    run(30, 1);
    cyc(1, 1, 0, 4);
    run(68, 1);
    check("chg_still_high", 64'(tone_out), 64'd1);
    cyc(1, 0, 0, 0);
    check("chg_fall", 64'(tone_out), 64'd0);
    check("chg_half", 64'(half_per), 64'd167);
    run(400, 1);

    // Octave scaling
    cyc(1, 1, 9, 5);
    run(200, 1);
    check("a5_half", 64'(half_per), 64'd50);
    cyc(1, 1, 9, 0);
    run(100, 1);
    check("a0_half", 64'(half_per), 64'd1600);
    cyc(1, 1, 11, 4);
    run(1650, 1);
    check("b4_half", 64'(half_per), 64'd89);

    // Clean stop in a high phase
    cyc(1, 1, 9, 4);
    wait_edge(1, 300);
    run(9, 1);
    cyc(0, 0, 0, 0);
    run(89, 0);
    check("drain_high", 64'(tone_out), 64'd1);
    check("drain_active", 64'(active), 64'd1);
    cyc(0, 0, 0, 0);
    check("drain_fall", 64'(tone_out), 64'd0);
    check("drain_idle", 64'(active), 64'd0);
    run(20, 0);

    // Stop in a low phase
    cyc(1, 0, 0, 0);
    wait_edge(0, 300);
    run(5, 1);
    cyc(0, 0, 0, 0);
    check("low_stop", 64'(active), 64'd0);
    run(5, 0);

    // Rest while running, then resume
    cyc(1, 0, 0, 0);
    run(20, 1);
    cyc(1, 1, 13, 4);
    run(300, 1);
    check("rest_tone", 64'(tone_out), 64'd0);
    check("rest_active", 64'(active), 64'd0);
    cyc(1, 1, 9, 4);
    check("resume_wait", 64'(tone_out), 64'd0);
    cyc(1, 0, 0, 0);
    check("resume_tone", 64'(tone_out), 64'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0),
          int'($urandom_range(0, 15)), int'($urandom_range(3, 7)));
    end

    // Asynchronous reset mid-drain
    cyc(1, 1, 9, 4);
    wait_edge(1, 1000);
    run(10, 1);
    cyc(0, 0, 0, 0);
    run(5, 0);
    check("pre_rst_active", 64'(active), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    run(5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
